// File: rtl/mips_pkg.sv
// Shared MIPS ALU codes, FSM state encoding and the arbiter request payload.
// Imported by the ALU and the two-port ALU arbiter.
package mips_pkg;

   localparam int DATA_W = 32;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_RTYPE = 2'b1?;

   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_SUB = 6'b100010;
   localparam logic [5:0] F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101;
   localparam logic [5:0] F_SLT = 6'b101010;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef struct packed {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [1:0]        alu_op;
      logic [5:0]        funct;
   } op_t;

   // One-hot winner; on a tie the requester that did not win last time goes.
   function automatic logic [1:0] rr_pick(input logic [1:0] vld, input logic last_grant);
      logic [1:0] win;
      case (vld)
         2'b01:   win = 2'b01;
         2'b10:   win = 2'b10;
         2'b11:   win = last_grant ? 2'b01 : 2'b10;
         default: win = 2'b00;
      endcase
      return win;
   endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two ALU requesters, the arbiter and the result consumer.
// master = requester/consumer side, slave = arbiter side.
interface alu_arbiter_if #(parameter int WIDTH = 32);

   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic [1:0]       req0_alu_op;
   logic [5:0]       req0_funct;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
   logic [1:0]       req1_alu_op;
   logic [5:0]       req1_funct;
   logic             resp_valid;
   logic             resp_ready;
   logic             resp_id;
   logic [WIDTH-1:0] resp_result;
   logic             resp_zero;

   modport master (
      output req_valid, req0_a, req0_b, req0_alu_op, req0_funct,
             req1_a, req1_b, req1_alu_op, req1_funct, resp_ready,
      input  req_ready, resp_valid, resp_id, resp_result, resp_zero
   );

   modport slave (
      input  req_valid, req0_a, req0_b, req0_alu_op, req0_funct,
             req1_a, req1_b, req1_alu_op, req1_funct, resp_ready,
      output req_ready, resp_valid, resp_id, resp_result, resp_zero
   );

endinterface

// File: rtl/Alu_final.sv
// 32-bit MIPS ALU: add/sub by alu_op, R-type decode by funct; unlisted funct yields 0.
// Latency: combinational. Backpressure: none.
// Add/sub wrap modulo 2^32; slt is signed.
module Alu_final
   import mips_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [1:0]  Alu_op,
   input  logic [5:0]  funct,
   output logic        zero,
   output logic [31:0] result
);

   always_comb begin
      result = '0;
      casez (Alu_op)
         ALU_ADD:   result = a + b;
         ALU_SUB:   result = a - b;
         ALU_RTYPE: begin
            case (funct)
               F_ADD:   result = a + b;
               F_SUB:   result = a - b;
               F_AND:   result = a & b;
               F_OR:    result = a | b;
               F_SLT:   result = {31'd0, $signed(a) < $signed(b)};
               default: result = '0;
            endcase
         end
         default:   result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin two-port arbiter/sequencer in front of one shared Alu_final.
// Latency: accept at edge N, registered response visible after edge N+1; one op in flight.
// Backpressure: resp_ready low parks the FSM in RESP; req_ready stays 0 until the result is taken.
module alu_arbiter
   import mips_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   alu_arbiter_if.slave bus,
   output logic         busy
);

   state_t           state;
   logic             last_grant;
   op_t              op_q;
   logic             id_q;
   logic [1:0]       grant;
   logic             grant_id;
   logic [WIDTH-1:0] alu_result;
   logic             alu_zero;

   // Grant is only offered in IDLE, so req_ready never sees resp_ready.
   assign grant         = (state == IDLE) ? rr_pick(bus.req_valid, last_grant) : 2'b00;
   assign grant_id      = grant[1];
   assign bus.req_ready = grant;
   assign busy          = (state != IDLE);

   Alu_final u_alu (
      .a      (op_q.a),
      .b      (op_q.b),
      .Alu_op (op_q.alu_op),
      .funct  (op_q.funct),
      .zero   (alu_zero),
      .result (alu_result)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         last_grant      <= 1'b1;
         op_q            <= '0;
         id_q            <= 1'b0;
         bus.resp_valid  <= 1'b0;
         bus.resp_id     <= 1'b0;
         bus.resp_result <= '0;
         bus.resp_zero   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (|grant) begin
                  op_q       <= grant_id ? op_t'{bus.req1_a, bus.req1_b, bus.req1_alu_op, bus.req1_funct}
                                         : op_t'{bus.req0_a, bus.req0_b, bus.req0_alu_op, bus.req0_funct};
                  id_q       <= grant_id;
                  last_grant <= grant_id;
                  state      <= EXEC;
               end
            end
            EXEC: begin
               bus.resp_result <= alu_result;
               bus.resp_zero   <= alu_zero;
               bus.resp_id     <= id_q;
               bus.resp_valid  <= 1'b1;
               state           <= RESP;
            end
            RESP: begin
               if (bus.resp_ready) begin
                  bus.resp_valid <= 1'b0;
                  state          <= IDLE;
               end
            end
            default: begin
               bus.resp_valid <= 1'b0;
               state          <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table of single operations plus
// hand-written tie, backpressure, mid-operation reset and alternation sequences.
module tb_alu_arbiter;

   logic clk;
   logic rst_n;
   logic busy;
   int   n_vec;
   int   n_err;

   alu_arbiter_if #(.WIDTH(32)) bus ();

   alu_arbiter #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          req;
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  alu_op;
      logic [5:0]  funct;
      logic [31:0] exp_result;
      logic        exp_zero;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive_req(input int r, input logic [31:0] a, input logic [31:0] b,
                            input logic [1:0] op, input logic [5:0] fn);
      if (r == 0) begin
         bus.req0_a = a; bus.req0_b = b; bus.req0_alu_op = op; bus.req0_funct = fn;
         bus.req_valid[0] = 1'b1;
      end else begin
         bus.req1_a = a; bus.req1_b = b; bus.req1_alu_op = op; bus.req1_funct = fn;
         bus.req_valid[1] = 1'b1;
      end
   endtask

   task automatic run_vec(input vec_t v);
      @(negedge clk);
      drive_req(v.req, v.a, v.b, v.alu_op, v.funct);
      #1;
      chk("vec_req_ready", {30'd0, bus.req_ready}, (v.req == 0) ? 32'd1 : 32'd2);
      @(posedge clk); #1;
      bus.req_valid = 2'b00;
      chk("vec_exec_busy", {31'd0, busy}, 32'd1);
      chk("vec_exec_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
      @(posedge clk); #1;
      chk("vec_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
      chk("vec_resp_id", {31'd0, bus.resp_id}, v.req[31:0]);
      chk("vec_result", bus.resp_result, v.exp_result);
      chk("vec_zero", {31'd0, bus.resp_zero}, {31'd0, v.exp_zero});
      @(posedge clk); #1;
      chk("vec_back_idle", {31'd0, busy}, 32'd0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req_ready"}, {30'd0, bus.req_ready}, 32'd0);
      chk({tag, "_resp_valid"}, {31'd0, bus.resp_valid}, 32'd0);
      chk({tag, "_resp_id"}, {31'd0, bus.resp_id}, 32'd0);
      chk({tag, "_resp_result"}, bus.resp_result, 32'd0);
      chk({tag, "_resp_zero"}, {31'd0, bus.resp_zero}, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int got;
      n_vec = 0;
      n_err = 0;

      vecs[0]  = '{0, 32'd25,        32'd23,        2'b00, 6'b100010, 32'd48,        1'b0};
      vecs[1]  = '{1, 32'd57,        32'd23,        2'b01, 6'b000000, 32'd34,        1'b0};
      vecs[2]  = '{1, 32'd3,         32'd3,         2'b10, 6'b100100, 32'd3,         1'b0};
      vecs[3]  = '{1, 32'd35,        32'd35,        2'b10, 6'b100010, 32'd0,         1'b1};
      vecs[4]  = '{0, 32'hFFFF_FFFF, 32'd0,         2'b11, 6'b101010, 32'd1,         1'b0};
      vecs[5]  = '{0, 32'd0,         32'hFFFF_FFFF, 2'b10, 6'b101010, 32'd0,         1'b1};
      vecs[6]  = '{1, 32'h0000_00F0, 32'h0000_000F, 2'b10, 6'b100101, 32'h0000_00FF, 1'b0};
      vecs[7]  = '{0, 32'hFFFF_FFFF, 32'd1,         2'b00, 6'b000000, 32'd0,         1'b1};
      vecs[8]  = '{0, 32'd0,         32'd1,         2'b01, 6'b000000, 32'hFFFF_FFFF, 1'b0};
      vecs[9]  = '{1, 32'd5,         32'd6,         2'b10, 6'b111111, 32'd0,         1'b1};
      vecs[10] = '{1, 32'd7,         32'd8,         2'b10, 6'b100000, 32'd15,        1'b0};
      vecs[11] = '{0, 32'h8000_0000, 32'd1,         2'b11, 6'b101010, 32'd1,         1'b0};

      bus.req_valid = 2'b00;
      bus.req0_a = '0; bus.req0_b = '0; bus.req0_alu_op = '0; bus.req0_funct = '0;
      bus.req1_a = '0; bus.req1_b = '0; bus.req1_alu_op = '0; bus.req1_funct = '0;
      bus.resp_ready = 1'b1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Tie straight out of reset: requester 0 first, then requester 1.
      @(negedge clk);
      drive_req(0, 32'd57, 32'd23, 2'b01, 6'b000000);
      drive_req(1, 32'd3, 32'd3, 2'b10, 6'b100100);
      #1;
      chk("tie_first_grant", {30'd0, bus.req_ready}, 32'd1);
      @(posedge clk); #1;
      bus.req_valid = 2'b10;
      chk("tie_exec_ready", {30'd0, bus.req_ready}, 32'd0);
      @(posedge clk); #1;
      chk("tie0_valid", {31'd0, bus.resp_valid}, 32'd1);
      chk("tie0_id", {31'd0, bus.resp_id}, 32'd0);
      chk("tie0_result", bus.resp_result, 32'd34);
      chk("tie_resp_ready_blocked", {30'd0, bus.req_ready}, 32'd0);
      @(posedge clk); #1;
      chk("tie_second_grant", {30'd0, bus.req_ready}, 32'd2);
      @(posedge clk); #1;
      bus.req_valid = 2'b00;
      @(posedge clk); #1;
      chk("tie1_valid", {31'd0, bus.resp_valid}, 32'd1);
      chk("tie1_id", {31'd0, bus.resp_id}, 32'd1);
      chk("tie1_result", bus.resp_result, 32'd3);
      @(posedge clk); #1;

      foreach (vecs[i]) run_vec(vecs[i]);

      // Backpressure: result held for 5 cycles while both requesters wait.
      @(negedge clk);
      bus.resp_ready = 1'b0;
      drive_req(0, 32'd10, 32'd4, 2'b01, 6'b000000);
      @(posedge clk); #1;
      bus.req_valid = 2'b00;
      @(posedge clk); #1;
      chk("bp_valid", {31'd0, bus.resp_valid}, 32'd1);
      drive_req(0, 32'd1, 32'd1, 2'b00, 6'b000000);
      drive_req(1, 32'd9, 32'd6, 2'b10, 6'b100101);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("bp_hold_valid", {31'd0, bus.resp_valid}, 32'd1);
         chk("bp_hold_result", bus.resp_result, 32'd6);
         chk("bp_hold_id", {31'd0, bus.resp_id}, 32'd0);
         chk("bp_hold_req_ready", {30'd0, bus.req_ready}, 32'd0);
      end
      bus.resp_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_valid", {31'd0, bus.resp_valid}, 32'd0);
      chk("bp_release_grant", {30'd0, bus.req_ready}, 32'd2);
      @(posedge clk); #1;
      bus.req_valid = 2'b00;
      @(posedge clk); #1;
      chk("bp_next_id", {31'd0, bus.resp_id}, 32'd1);
      chk("bp_next_result", bus.resp_result, 32'd15);
      @(posedge clk); #1;

      // Reset during EXEC discards the operation.
      @(negedge clk);
      drive_req(0, 32'd1, 32'd2, 2'b00, 6'b000000);
      @(posedge clk); #1;
      bus.req_valid = 2'b00;
      chk("rst_mid_busy", {31'd0, busy}, 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("rst_mid");
      @(negedge clk);
      rst_n = 1'b1;
      got = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (bus.resp_valid) got++;
      end
      chk("rst_mid_no_resp", got, 32'd0);

      // Alternation with both requesters held valid; first tie after reset goes to 0.
      @(negedge clk);
      drive_req(0, 32'd1, 32'd1, 2'b00, 6'b000000);
      drive_req(1, 32'd6, 32'd3, 2'b10, 6'b100100);
      got = 0;
      for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
         @(posedge clk); #1;
         if (bus.resp_valid) begin
            chk("alt_id", {31'd0, bus.resp_id}, got % 2);
            chk("alt_result", bus.resp_result, 32'd2);
            got++;
         end
      end
      bus.req_valid = 2'b00;
      chk("alt_count", got, 32'd4);
      repeat (4) @(posedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
